// File: rtl/proc_mem_pkg.sv
// Shared defaults and types for the processor memory responder and its write log.
package proc_mem_pkg;

  localparam int DATA_W_DEF     = 16;
  localparam int ADDR_W_DEF     = 16;
  localparam int MAX_RD_LATENCY = 4;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } log_entry_t;

endpackage

// File: rtl/proc_mem_log_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count and sticky overflow.
module proc_mem_log_fifo #(
  parameter int  W     = 32,
  parameter int  DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop_ready,
  output logic             valid,
  output logic [W-1:0]     head_data,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  logic [W-1:0]     store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, pop, push_ok;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    full       = (count_q == CNT_W'(DEPTH));
    pop        = (count_q != '0) && pop_ready;
    push_ok    = push && (!full || pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push_ok) count_d = count_q - CNT_W'(1);
    if (push && !push_ok) overflow_d = 1'b1;
  end

  // NOTE: state flops use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: storage has no reset; pointers and count alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) store_q[wr_ptr_q] <= push_data;
  end

  assign valid     = (count_q != '0);
  assign head_data = store_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/proc_mem_responder.sv
// Active memory model for the basic processor: latency-configurable reads, preload,
// processor writes, and a write log drained by the scoreboard.
module proc_mem_responder
  import proc_mem_pkg::*;
#(
  parameter int  DATA_W     = DATA_W_DEF,
  parameter int  ADDR_W     = ADDR_W_DEF,
  parameter int  DEPTH      = 256,
  parameter int  RD_LATENCY = 1,
  parameter int  LOG_DEPTH  = 8,
  localparam int CNT_W      = $clog2(LOG_DEPTH + 1)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_memAddr,
  input  logic [DATA_W-1:0] i_memData,
  input  logic              i_memWrEnable,
  output logic [DATA_W-1:0] o_memData,
  output logic              o_rdValid,
  input  logic              i_preloadEn,
  input  logic [ADDR_W-1:0] i_preloadAddr,
  input  logic [DATA_W-1:0] i_preloadData,
  output logic              o_logValid,
  input  logic              i_logReady,
  output logic [ADDR_W-1:0] o_logAddr,
  output logic [DATA_W-1:0] o_logData,
  output logic [CNT_W-1:0]  o_logCount,
  output logic              o_logOverflow,
  output logic              o_addrErr,
  output logic              o_wrConflict
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int PIPE_N = (RD_LATENCY < 1) ? 1 :
                          (RD_LATENCY > MAX_RD_LATENCY) ? MAX_RD_LATENCY : RD_LATENCY;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]  mem_idx, pre_idx;
  logic              wr_proc, rd_issue, addr_bad;
  logic              addr_err_q, addr_err_d, wr_conflict_q, wr_conflict_d;
  logic              rd_valid_q [PIPE_N];
  logic              rd_valid_d [PIPE_N];
  logic [DATA_W-1:0] rd_data_q  [PIPE_N];
  logic [DATA_W-1:0] rd_data_d  [PIPE_N];
  logic [ADDR_W+DATA_W-1:0] log_head;

  always_comb begin
    wr_proc  = i_memWrEnable && !i_preloadEn;
    rd_issue = !(i_memWrEnable || i_preloadEn);
    mem_idx  = i_memAddr[IDX_W-1:0];
    pre_idx  = i_preloadAddr[IDX_W-1:0];
    // The processor address is live on reads and on writes, even a write that loses to preload.
    addr_bad = ((i_memWrEnable || !i_preloadEn) && ((i_memAddr >> IDX_W) != '0)) ||
               (i_preloadEn && ((i_preloadAddr >> IDX_W) != '0));
    addr_err_d    = addr_err_q || addr_bad;
    wr_conflict_d = wr_conflict_q || (i_preloadEn && i_memWrEnable);

    // Each stage only takes new data from a valid slot, so the output holds its last read.
    rd_valid_d[0] = rd_issue;
    rd_data_d[0]  = rd_issue ? mem_q[mem_idx] : rd_data_q[0];
    for (int i = 1; i < PIPE_N; i++) begin
      rd_valid_d[i] = rd_valid_q[i-1];
      rd_data_d[i]  = rd_valid_q[i-1] ? rd_data_q[i-1] : rd_data_q[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_err_q    <= 1'b0;
      wr_conflict_q <= 1'b0;
      for (int i = 0; i < PIPE_N; i++) begin
        rd_valid_q[i] <= 1'b0;
        rd_data_q[i]  <= '0;
      end
    end else begin
      addr_err_q    <= addr_err_d;
      wr_conflict_q <= wr_conflict_d;
      for (int i = 0; i < PIPE_N; i++) begin
        rd_valid_q[i] <= rd_valid_d[i];
        rd_data_q[i]  <= rd_data_d[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_preloadEn)        mem_q[pre_idx] <= i_preloadData;
    else if (i_memWrEnable) mem_q[mem_idx] <= i_memData;
  end

  generate
    if (RD_LATENCY == 0) begin : g_comb_read
      assign o_memData = i_rst ? mem_q[mem_idx] : '0;
      assign o_rdValid = i_rst && rd_issue;
    end else begin : g_pipe_read
      assign o_memData = rd_data_q[PIPE_N-1];
      assign o_rdValid = rd_valid_q[PIPE_N-1];
    end
  endgenerate

  proc_mem_log_fifo #(
    .W     (ADDR_W + DATA_W),
    .DEPTH (LOG_DEPTH)
  ) u_log_fifo (
    .clk       (i_clk),
    .rst_n     (i_rst),
    .push      (wr_proc),
    .push_data ({i_memAddr, i_memData}),
    .pop_ready (i_logReady),
    .valid     (o_logValid),
    .head_data (log_head),
    .count     (o_logCount),
    .overflow  (o_logOverflow)
  );

  assign o_logAddr    = log_head[ADDR_W+DATA_W-1:DATA_W];
  assign o_logData    = log_head[DATA_W-1:0];
  assign o_addrErr    = addr_err_q;
  assign o_wrConflict = wr_conflict_q;

endmodule

// File: tb/tb_proc_mem_responder.sv
// Directed bench for proc_mem_responder with RD_LATENCY=2, DEPTH=256, LOG_DEPTH=8.
module tb_proc_mem_responder;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int CNT_W  = 4;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b0;
  logic [ADDR_W-1:0] i_memAddr = '0;
  logic [DATA_W-1:0] i_memData = '0;
  logic              i_memWrEnable = 1'b0;
  logic [DATA_W-1:0] o_memData;
  logic              o_rdValid;
  logic              i_preloadEn = 1'b0;
  logic [ADDR_W-1:0] i_preloadAddr = '0;
  logic [DATA_W-1:0] i_preloadData = '0;
  logic              o_logValid;
  logic              i_logReady = 1'b0;
  logic [ADDR_W-1:0] o_logAddr;
  logic [DATA_W-1:0] o_logData;
  logic [CNT_W-1:0]  o_logCount;
  logic              o_logOverflow;
  logic              o_addrErr;
  logic              o_wrConflict;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  proc_mem_responder #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(256), .RD_LATENCY(2), .LOG_DEPTH(8)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_memAddr(i_memAddr), .i_memData(i_memData), .i_memWrEnable(i_memWrEnable),
    .o_memData(o_memData), .o_rdValid(o_rdValid),
    .i_preloadEn(i_preloadEn), .i_preloadAddr(i_preloadAddr), .i_preloadData(i_preloadData),
    .o_logValid(o_logValid), .i_logReady(i_logReady),
    .o_logAddr(o_logAddr), .o_logData(o_logData), .o_logCount(o_logCount),
    .o_logOverflow(o_logOverflow), .o_addrErr(o_addrErr), .o_wrConflict(o_wrConflict)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " rdValid"},  32'(o_rdValid), 32'h0);
    check({tag, " memData"},  32'(o_memData), 32'h0);
    check({tag, " logValid"}, 32'(o_logValid), 32'h0);
    check({tag, " logCount"}, 32'(o_logCount), 32'h0);
    check({tag, " overflow"}, 32'(o_logOverflow), 32'h0);
    check({tag, " addrErr"},  32'(o_addrErr), 32'h0);
    check({tag, " conflict"}, 32'(o_wrConflict), 32'h0);
  endtask

  initial begin
    // Reset state
    #3;
    check_reset_state("por");
    tick(); tick();
    @(negedge i_clk) i_rst = 1'b1;
    tick();

    // Preload then read with two-cycle latency
    i_preloadEn = 1'b1; i_preloadAddr = 16'h0010; i_preloadData = 16'hBEEF;
    tick();
    i_preloadEn = 1'b0; i_memAddr = 16'h0010;
    tick();
    check("rd lat1 valid", 32'(o_rdValid), 32'h0);
    tick();
    check("rd lat2 valid", 32'(o_rdValid), 32'h1);
    check("rd lat2 data",  32'(o_memData), 32'hBEEF);

    // Two logged processor writes, then drain in order
    i_memWrEnable = 1'b1; i_memAddr = 16'h0005; i_memData = 16'h1234;
    tick();
    i_memAddr = 16'h0006; i_memData = 16'h5678;
    tick();
    i_memWrEnable = 1'b0;
    check("log2 count", 32'(o_logCount), 32'd2);
    check("log2 valid", 32'(o_logValid), 32'h1);
    check("log2 head addr", 32'(o_logAddr), 32'h0005);
    check("log2 head data", 32'(o_logData), 32'h1234);
    i_logReady = 1'b1;
    tick();
    check("pop1 count", 32'(o_logCount), 32'd1);
    check("pop1 head addr", 32'(o_logAddr), 32'h0006);
    check("pop1 head data", 32'(o_logData), 32'h5678);
    tick();
    check("pop2 count", 32'(o_logCount), 32'd0);
    check("pop2 valid", 32'(o_logValid), 32'h0);
    i_logReady = 1'b0;

    // Nine writes into an eight-entry log
    i_memWrEnable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      i_memAddr = 16'h0020 + 16'(i); i_memData = 16'h1000 + 16'(i);
      tick();
      if (i == 7) check("fill8 overflow", 32'(o_logOverflow), 32'h0);
    end
    i_memWrEnable = 1'b0; i_memAddr = 16'h0028;
    check("ovf count", 32'(o_logCount), 32'd8);
    check("ovf flag", 32'(o_logOverflow), 32'h1);
    check("ovf head addr", 32'(o_logAddr), 32'h0020);
    tick(); tick();
    check("ovf 9th in mem", 32'(o_memData), 32'h1008);

    // Reset clears log and flag, then fill and push+pop at full
    i_rst = 1'b0;
    #1;
    check("rst2 count", 32'(o_logCount), 32'd0);
    check("rst2 overflow", 32'(o_logOverflow), 32'h0);
    @(negedge i_clk) i_rst = 1'b1;
    tick();
    i_memWrEnable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      i_memAddr = 16'h0030 + 16'(i); i_memData = 16'h2000 + 16'(i);
      tick();
    end
    check("full count", 32'(o_logCount), 32'd8);
    i_memAddr = 16'h0038; i_memData = 16'h2008; i_logReady = 1'b1;
    tick();
    i_memWrEnable = 1'b0;
    check("full pushpop count", 32'(o_logCount), 32'd8);
    check("full pushpop overflow", 32'(o_logOverflow), 32'h0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain%0d addr", i), 32'(o_logAddr), 32'h0031 + i);
      tick();
    end
    check("drain count", 32'(o_logCount), 32'd0);
    i_logReady = 1'b0;

    // Preload and processor write collide on the same address
    i_preloadEn = 1'b1; i_preloadAddr = 16'h0003; i_preloadData = 16'hAAAA;
    i_memWrEnable = 1'b1; i_memAddr = 16'h0003; i_memData = 16'h5555;
    tick();
    i_preloadEn = 1'b0; i_memWrEnable = 1'b0;
    check("conflict flag", 32'(o_wrConflict), 32'h1);
    check("conflict no log", 32'(o_logCount), 32'd0);
    check("conflict addrErr", 32'(o_addrErr), 32'h0);
    tick(); tick();
    check("conflict rd valid", 32'(o_rdValid), 32'h1);
    check("conflict rd data", 32'(o_memData), 32'hAAAA);

    // Out-of-range address wraps into the array
    i_memWrEnable = 1'b1; i_memAddr = 16'h0105; i_memData = 16'h00FF;
    tick();
    i_memWrEnable = 1'b0; i_memAddr = 16'h0005;
    check("addrErr flag", 32'(o_addrErr), 32'h1);
    check("addrErr log addr", 32'(o_logAddr), 32'h0105);
    tick(); tick();
    check("wrap rd data", 32'(o_memData), 32'h00FF);

    // Asynchronous reset mid-read with three log entries
    i_memWrEnable = 1'b1;
    i_memAddr = 16'h0040; i_memData = 16'h4444; tick();
    i_memAddr = 16'h0041; i_memData = 16'h4141; tick();
    i_memWrEnable = 1'b0; i_memAddr = 16'h0040;
    check("pre-rst count", 32'(o_logCount), 32'd3);
    tick();
    #2 i_rst = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge i_clk) i_rst = 1'b1;
    tick(); tick();
    check("post-rst rd valid", 32'(o_rdValid), 32'h1);
    check("post-rst rd data", 32'(o_memData), 32'h4444);
    i_memAddr = 16'h0010;
    tick(); tick();
    check("persist rd data", 32'(o_memData), 32'hBEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/proc_mem_responder.md
Name: proc_mem_responder

Overview:
- Parametrised memory-side responder for the basic-processor verification environment.
- Replaces the fixed 16-bit passive memory connection with an active, synthesizable memory model.
- Serves processor reads with configurable latency, applies processor writes, and supports testbench preload.
- Records every accepted write in a write-log FIFO that the scoreboard drains through a valid/ready handshake.

Parameters:
- DATA_W, 16, memory data width.
- ADDR_W, 16, processor address width.
- DEPTH, 256, number of words; must be a power of two and no larger than 2**ADDR_W.
- RD_LATENCY, 1, read latency in cycles; legal range 0..4.
- LOG_DEPTH, 8, write-log FIFO entries; must be a power of two.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_memAddr  in  ADDR_W  processor address.
- i_memData  in  DATA_W  processor write data.
- i_memWrEnable  in  1  processor write strobe.
- o_memData  out  DATA_W  read data to the processor.
- o_rdValid  out  1  o_memData holds a completed read.
- i_preloadEn  in  1  testbench preload write.
- i_preloadAddr  in  ADDR_W  preload address.
- i_preloadData  in  DATA_W  preload data.
- o_logValid  out  1  log head entry available.
- i_logReady  in  1  consumer accepts the head entry.
- o_logAddr  out  ADDR_W  head entry address.
- o_logData  out  DATA_W  head entry data.
- o_logCount  out  $clog2(LOG_DEPTH+1)  number of log entries.
- o_logOverflow  out  1  sticky: a log push was dropped.
- o_addrErr  out  1  sticky: out-of-range address used.
- o_wrConflict  out  1  sticky: a processor write was dropped in favour of a preload.

Behaviour:
- Reset (i_rst low, asynchronous):
  - o_memData=0, o_rdValid=0, o_logValid=0, o_logCount=0.
  - All sticky flags cleared; read pipeline and FIFO pointers cleared.
  - Memory array is not reset; contents persist across reset.
- Address mapping: array index = low $clog2(DEPTH) bits of the address, so addresses wrap. Any nonzero upper bit on an active access (read, write or preload) sets o_addrErr.
- Write arbitration, evaluated at each rising edge:
  - i_preloadEn=1: preload writes the array.
  - i_preloadEn=1 and i_memWrEnable=1 together: preload wins, processor write is dropped and not logged, o_wrConflict set.
  - Otherwise i_memWrEnable=1: processor write is applied and pushed to the log.
- Reads:
  - Every cycle with i_memWrEnable=0 and i_preloadEn=0 issues a read of i_memAddr.
  - Read data appears on o_memData with o_rdValid=1 exactly RD_LATENCY cycles later.
  - Cycles that write issue no read; the matching pipeline slot carries o_rdValid=0 and o_memData holds its last value.
  - RD_LATENCY=0: combinational array read; o_rdValid = !(i_memWrEnable | i_preloadEn).
  - Read data reflects array state before any same-edge write (read-before-write). Pipelined reads issued before a write to the same address return the old data.
- Write log:
  - FIFO of {addr, data}. Head presented first-word-fall-through; o_logValid = (count != 0).
  - Pop when o_logValid & i_logReady.
  - Push and pop in the same cycle: count unchanged, allowed even when full.
  - Push when full without a pop: entry dropped, o_logOverflow set, count stays LOG_DEPTH.
  - Pop when empty: ignored.
  - Pointers wrap modulo LOG_DEPTH.
- Sticky flags clear only on reset.

Decomposition:
- Package proc_mem_pkg:
  - Defaults for DATA_W and ADDR_W.
  - Typedef log_entry_t (addr, data) packed struct.
  - Localparam for max RD_LATENCY (4).
- Sub-module proc_mem_log_fifo: parametrised sync FIFO (valid/ready, count, overflow) instantiated once. Memory array and read pipeline stay in the top.

Test Plan:
- Preload addr 0x0010=0xBEEF, then read 0x0010 with RD_LATENCY=2 -> o_memData=0xBEEF, o_rdValid=1 exactly 2 cycles after the issue cycle, 0 between.
- Processor write 0x0005=0x1234 then 0x0006=0x5678, i_logReady=0 -> o_logCount=2, head {0x0005,0x1234}. Raise i_logReady -> entries pop in order, count returns to 0.
- LOG_DEPTH=8: 9 writes with i_logReady=0 -> count=8, o_logOverflow=1, 9th write absent from log but present in memory. Repeat full with simultaneous push+pop -> no overflow.
- i_preloadEn and i_memWrEnable together on addr 0x0003 (preload 0xAAAA, processor 0x5555) -> read returns 0xAAAA, o_wrConflict=1, no log entry.
- DEPTH=256: write to 0x0105=0x00FF -> o_addrErr=1; read of 0x0005 returns 0x00FF (wrap).
- Assert i_rst low mid-read with FIFO holding 3 entries -> o_rdValid=0, o_logCount=0, flags cleared immediately. After release, a read of a previously written address returns its data.
